// File: rtl/dmem_axi_master.sv
// AXI4-Lite initiator for the core's data-memory port: one single-beat load or store at a time,
// with byte-lane strobes, load sign/zero extension and misalignment trapping before the bus.
module dmem_axi_master #(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESET,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [31:0]             REQ_ADDR,
  input  logic [1:0]              REQ_SIZE,
  input  logic                    REQ_UNSIGNED,
  input  logic [31:0]             REQ_WDATA,
  output logic                    RESP_VALID,
  output logic [31:0]             RESP_RDATA,
  output logic                    RESP_ERR,
  output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lo[0];
      2'b10:   is_misaligned = (lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   byte_strobe = 4'b0001 << lo;
      2'b01:   byte_strobe = 4'b0011 << lo;
      default: byte_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] beat, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [31:0] sh;
    sh = beat >> {lo, 3'b000};
    case (size)
      2'b00:   extract_load = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract_load = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract_load = sh;
    endcase
  endfunction

  state_t                  state_r;
  logic                    we_r, unsigned_r, err_r;
  logic [1:0]              size_r, lo_r;
  logic [31:0]             beat_r;
  logic                    aw_done_r, w_done_r, b_seen_r, r_seen_r;
  logic                    resp_valid_r, resp_err_r;
  logic [31:0]             resp_rdata_r;
  logic [AXI_AWIDTH-1:0]   awaddr_r, araddr_r;
  logic [AXI_DWIDTH-1:0]   wdata_r;
  logic [AXI_DWIDTH/8-1:0] wstrb_r;
  logic                    awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
  logic                    aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic                    aw_all_s, w_all_s, b_all_s, r_all_s;
  logic                    unused_addr_s;

  assign aw_hs_s  = awvalid_r & AXI_AWREADY;
  assign w_hs_s   = wvalid_r & AXI_WREADY;
  assign b_hs_s   = bready_r & AXI_BVALID;
  assign ar_hs_s  = arvalid_r & AXI_ARREADY;
  assign r_hs_s   = rready_r & AXI_RVALID;
  assign aw_all_s = aw_done_r | aw_hs_s;
  assign w_all_s  = w_done_r | w_hs_s;
  assign b_all_s  = b_seen_r | b_hs_s;
  assign r_all_s  = r_seen_r | r_hs_s;
  assign unused_addr_s = ^REQ_ADDR[31:AXI_AWIDTH+2];

  // Held low during the response pulse so the next request lands in the cycle after it.
  assign REQ_READY   = (state_r == ST_IDLE) && !resp_valid_r;
  assign RESP_VALID  = resp_valid_r;
  assign RESP_RDATA  = resp_rdata_r;
  assign RESP_ERR    = resp_err_r;
  assign AXI_AWADDR  = awaddr_r;
  assign AXI_AWVALID = awvalid_r;
  assign AXI_WDATA   = wdata_r;
  assign AXI_WSTRB   = wstrb_r;
  assign AXI_WVALID  = wvalid_r;
  assign AXI_BREADY  = bready_r;
  assign AXI_ARADDR  = araddr_r;
  assign AXI_ARVALID = arvalid_r;
  assign AXI_RREADY  = rready_r;

  // Transaction sequencer with all bus and response outputs registered.
  always_ff @(posedge AXI_ACLK or posedge AXI_ARESET) begin
    if (AXI_ARESET) begin
      state_r      <= ST_IDLE;
      we_r         <= 1'b0;
      unsigned_r   <= 1'b0;
      err_r        <= 1'b0;
      size_r       <= 2'b00;
      lo_r         <= 2'b00;
      beat_r       <= 32'h0;
      aw_done_r    <= 1'b0;
      w_done_r     <= 1'b0;
      b_seen_r     <= 1'b0;
      r_seen_r     <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0;
      awaddr_r     <= '0;
      araddr_r     <= '0;
      wdata_r      <= '0;
      wstrb_r      <= '0;
      awvalid_r    <= 1'b0;
      wvalid_r     <= 1'b0;
      bready_r     <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
    end else begin
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            we_r       <= REQ_WE;
            size_r     <= REQ_SIZE;
            lo_r       <= REQ_ADDR[1:0];
            unsigned_r <= REQ_UNSIGNED;
            err_r      <= 1'b0;
            beat_r     <= 32'h0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            b_seen_r   <= 1'b0;
            r_seen_r   <= 1'b0;
            if (is_misaligned(REQ_SIZE, REQ_ADDR[1:0])) begin
              err_r   <= 1'b1;
              state_r <= ST_DONE;
            end else if (REQ_WE) begin
              awaddr_r  <= REQ_ADDR[AXI_AWIDTH+1:2];
              wdata_r   <= REQ_WDATA << {REQ_ADDR[1:0], 3'b000};
              wstrb_r   <= byte_strobe(REQ_SIZE, REQ_ADDR[1:0]);
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              bready_r  <= 1'b1;
              state_r   <= ST_WRITE;
            end else begin
              araddr_r  <= REQ_ADDR[AXI_AWIDTH+1:2];
              arvalid_r <= 1'b1;
              rready_r  <= 1'b1;
              state_r   <= ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (b_hs_s) begin
            bready_r <= 1'b0;
            b_seen_r <= 1'b1;
            err_r    <= (AXI_BRESP != 2'b00);
          end
          if (aw_all_s && w_all_s) begin
            state_r <= b_all_s ? ST_DONE : ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (b_hs_s) begin
            bready_r <= 1'b0;
            err_r    <= (AXI_BRESP != 2'b00);
            state_r  <= ST_DONE;
          end
        end
        ST_READ: begin
          if (r_hs_s) begin
            rready_r <= 1'b0;
            r_seen_r <= 1'b1;
            beat_r   <= AXI_RDATA;
            err_r    <= (AXI_RRESP != 2'b00);
          end
          if (ar_hs_s) begin
            arvalid_r <= 1'b0;
            state_r   <= r_all_s ? ST_DONE : ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (r_hs_s) begin
            rready_r <= 1'b0;
            beat_r   <= AXI_RDATA;
            err_r    <= (AXI_RRESP != 2'b00);
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          resp_valid_r <= 1'b1;
          resp_err_r   <= err_r;
          resp_rdata_r <= we_r ? 32'h0 : extract_load(beat_r, size_r, lo_r, unsigned_r);
          state_r      <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_axi_master.sv
// Scoreboard bench for dmem_axi_master: a small AXI4-Lite memory responder plus response,
// write-beat and protocol monitors checking against hand-computed expectations.
module tb_dmem_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        REQ_VALID, REQ_READY, REQ_WE, REQ_UNSIGNED;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        RESP_VALID, RESP_ERR;
  logic [31:0] RESP_RDATA;
  logic [3:0]  AXI_AWADDR, AXI_ARADDR, AXI_WSTRB;
  logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY, AXI_BVALID, AXI_BREADY;
  logic        AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
  logic [31:0] AXI_WDATA, AXI_RDATA;
  logic [1:0]  AXI_BRESP, AXI_RRESP;

  dmem_axi_master #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_WDATA(REQ_WDATA),
    .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA), .RESP_ERR(RESP_ERR),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; int acc; int lat; } resp_t;
  typedef struct { logic [3:0] addr; logic [3:0] strb; logic [31:0] data; } wr_t;
  resp_t exp_q[$];
  wr_t   wexp_q[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, resp_cnt = 0, exp_total = 0;
  int valid_cnt = 0, ar_cnt = 0, overlap_cnt = 0, stab_err = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Responder: word memory, configurable W delay, B/R response codes, R hold/force.
  logic [31:0] mem [16] = '{default: 32'h0};
  logic        aw_got, w_got, ar_got;
  logic [3:0]  aw_q, ar_q, s_q;
  logic [31:0] w_q;
  int          aw_age;
  int          w_delay = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  logic        r_hold = 1'b0, r_force = 1'b0;
  logic        aw_now, w_now, ar_now;
  logic [3:0]  cur_a, cur_s;
  logic [31:0] cur_d;

  assign aw_now      = AXI_AWVALID & AXI_AWREADY;
  assign w_now       = AXI_WVALID & AXI_WREADY;
  assign ar_now      = AXI_ARVALID & AXI_ARREADY;
  assign AXI_AWREADY = !aw_got;
  assign AXI_WREADY  = !w_got && (w_delay == 0 || (aw_got && aw_age >= w_delay));
  assign AXI_BVALID  = (aw_got | aw_now) && (w_got | w_now);
  assign AXI_BRESP   = bresp_val;
  assign AXI_ARREADY = !ar_got;
  assign AXI_RVALID  = r_force || (!r_hold && (ar_got | ar_now));
  assign AXI_RDATA   = mem[ar_got ? ar_q : AXI_ARADDR];
  assign AXI_RRESP   = rresp_val;
  assign cur_a = aw_got ? aw_q : AXI_AWADDR;
  assign cur_d = w_got ? w_q : AXI_WDATA;
  assign cur_s = w_got ? s_q : AXI_WSTRB;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; aw_age <= 0;
      aw_q <= 4'h0; ar_q <= 4'h0; s_q <= 4'h0; w_q <= 32'h0;
    end else begin
      if (aw_now) begin aw_got <= 1'b1; aw_q <= AXI_AWADDR; aw_age <= 0; aw_hs_cyc <= cyc; end
      else if (aw_got) aw_age <= aw_age + 1;
      if (w_now) begin w_got <= 1'b1; w_q <= AXI_WDATA; s_q <= AXI_WSTRB; w_hs_cyc <= cyc; end
      if (AXI_BVALID && AXI_BREADY) begin
        for (int i = 0; i < 4; i++)
          if (cur_s[i]) mem[cur_a][8*i +: 8] <= cur_d[8*i +: 8];
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (ar_now) begin ar_got <= 1'b1; ar_q <= AXI_ARADDR; end
      if (AXI_RVALID && AXI_RREADY) ar_got <= 1'b0;
    end
  end

  // Response monitor: pops the scoreboard on every RESP_VALID.
  initial forever begin
    @(negedge clk);
    if (!rst && RESP_VALID) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        check("resp without request", 64'(exp_q.size()), 64'd1);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp rdata", 64'(RESP_RDATA), 64'(e.rdata));
        check("resp err", 64'(RESP_ERR), 64'(e.err));
        if (e.lat >= 0) check("resp latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  // Write-beat monitor and protocol watchers.
  logic       p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rst;
  logic [3:0] p_awa, p_ara, p_ws;
  logic [31:0] p_wd;
  initial begin
    p_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && AXI_BVALID && AXI_BREADY) begin
        if (wexp_q.size() == 0) begin
          check("write without request", 64'(wexp_q.size()), 64'd1);
        end else begin
          wr_t w;
          w = wexp_q.pop_front();
          check("aw addr", 64'(cur_a), 64'(w.addr));
          check("w strb", 64'(cur_s), 64'(w.strb));
          check("w data", 64'(cur_d), 64'(w.data));
        end
      end
      if (AXI_AWVALID | AXI_WVALID | AXI_ARVALID) valid_cnt++;
      if (AXI_ARVALID) ar_cnt++;
      if ((AXI_AWVALID | AXI_WVALID) && AXI_ARVALID) overlap_cnt++;
      if (!rst && !p_rst) begin
        if (p_awv && !p_awr && (!AXI_AWVALID || AXI_AWADDR != p_awa)) stab_err++;
        if (p_wv && !p_wr && (!AXI_WVALID || AXI_WDATA != p_wd || AXI_WSTRB != p_ws)) stab_err++;
        if (p_arv && !p_arr && (!AXI_ARVALID || AXI_ARADDR != p_ara)) stab_err++;
      end
      p_awv = AXI_AWVALID; p_awr = AXI_AWREADY; p_awa = AXI_AWADDR;
      p_wv = AXI_WVALID; p_wr = AXI_WREADY; p_wd = AXI_WDATA; p_ws = AXI_WSTRB;
      p_arv = AXI_ARVALID; p_arr = AXI_ARREADY; p_ara = AXI_ARADDR;
      p_rst = rst;
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input logic push,
                       input logic [31:0] er, input logic ee, input int lat);
    int k;
    @(negedge clk);
    REQ_WE = we; REQ_ADDR = addr; REQ_SIZE = size; REQ_UNSIGNED = uns; REQ_WDATA = wd;
    REQ_VALID = 1'b1;
    k = 0;
    while (!REQ_READY && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) check("req ready timeout", 64'(REQ_READY), 64'd1);
    if (push) begin
      exp_q.push_back('{rdata: er, err: ee, acc: cyc, lat: lat});
      exp_total++;
    end
    @(posedge clk);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic wait_resp();
    for (int k = 0; k < 60 && resp_cnt < exp_total; k++) @(negedge clk);
    if (resp_cnt < exp_total) check("resp timeout", 64'(resp_cnt), 64'(exp_total));
  endtask

  task automatic store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                       input logic [3:0] ea, input logic [3:0] es, input logic [31:0] ed);
    wexp_q.push_back('{addr: ea, strb: es, data: ed});
    issue(1'b1, addr, size, 1'b0, wd, 1'b1, 32'h0, 1'b0, 3);
    wait_resp();
  endtask

  task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                      input logic [31:0] er, input logic ee);
    issue(1'b0, addr, size, uns, 32'h0, 1'b1, er, ee, 3);
    wait_resp();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ctrl"}, 64'({REQ_READY, RESP_VALID, RESP_ERR, AXI_AWVALID, AXI_WVALID,
                               AXI_BREADY, AXI_ARVALID, AXI_RREADY}), 64'h80);
    check({tag, " rdata"}, 64'(RESP_RDATA), 64'h0);
    check({tag, " bus"}, 64'({AXI_AWADDR, AXI_ARADDR, AXI_WSTRB, AXI_WDATA}), 64'h0);
  endtask

  initial begin
    int v0, a0, r0;
    rst = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = 32'h0; REQ_SIZE = 2'b00;
    REQ_UNSIGNED = 1'b0; REQ_WDATA = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    a0 = ar_cnt;
    store(32'h0000000C, 2'b10, 32'hDEADBEEF, 4'd3, 4'b1111, 32'hDEADBEEF);
    check("SW no AR", 64'(ar_cnt - a0), 64'd0);
    store(32'h00000000, 2'b10, 32'h80011234, 4'd0, 4'b1111, 32'h80011234);
    store(32'h00000006, 2'b00, 32'h000000A5, 4'd1, 4'b0100, 32'h00A50000);

    load(32'h00000006, 2'b00, 1'b0, 32'hFFFFFFA5, 1'b0);
    load(32'h00000006, 2'b00, 1'b1, 32'h000000A5, 1'b0);
    load(32'h00000002, 2'b01, 1'b0, 32'hFFFF8001, 1'b0);
    load(32'h00000002, 2'b01, 1'b1, 32'h00008001, 1'b0);
    load(32'h00000001, 2'b00, 1'b0, 32'h00000012, 1'b0);
    load(32'h00000000, 2'b01, 1'b0, 32'h00001234, 1'b0);
    load(32'h0000000C, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

    // Misaligned requests: error after two cycles, nothing on the bus.
    v0 = valid_cnt;
    issue(1'b0, 32'h00000005, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 2);
    wait_resp();
    issue(1'b1, 32'h00000003, 2'b01, 1'b0, 32'h1234, 1'b1, 32'h0, 1'b1, 2);
    wait_resp();
    issue(1'b0, 32'h00000000, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 2);
    wait_resp();
    check("misaligned bus idle", 64'(valid_cnt - v0), 64'd0);

    // Slow W channel and SLVERR write response.
    w_delay = 3; bresp_val = 2'b10;
    wexp_q.push_back('{addr: 4'd2, strb: 4'b1111, data: 32'h11223344});
    issue(1'b1, 32'h00000008, 2'b10, 1'b0, 32'h11223344, 1'b1, 32'h0, 1'b1, -1);
    @(negedge clk);
    @(negedge clk);
    check("AW drops before W", 64'({AXI_AWVALID, AXI_WVALID}), 64'b01);
    wait_resp();
    check("W delayed after AW", 64'(w_hs_cyc - aw_hs_cyc >= 3), 64'd1);
    w_delay = 0; bresp_val = 2'b00;

    rresp_val = 2'b10;
    load(32'h00000000, 2'b10, 1'b0, 32'h80011234, 1'b1);
    rresp_val = 2'b00;

    // Reset while waiting for read data abandons the load.
    r_hold = 1'b1;
    issue(1'b0, 32'h0000000C, 2'b10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    check("in RDATA", 64'({AXI_ARVALID, AXI_RREADY}), 64'b01);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid reset");
    r_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    r_force = 1'b1;
    r0 = resp_cnt;
    repeat (4) @(negedge clk);
    r_force = 1'b0;
    check("late R ignored", 64'(resp_cnt - r0), 64'd0);
    load(32'h0000000C, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

    repeat (3) @(negedge clk);
    check("AW/AR overlap", 64'(overlap_cnt), 64'd0);
    check("valid stability", 64'(stab_err), 64'd0);
    check("writes pending", 64'(wexp_q.size()), 64'd0);
    check("resps pending", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
